// File: rtl/sig_timing_monitor_pkg.sv
// Shared types and helpers for the signal timing monitor.
// Channel state encoding and the saturating counter increment.
package sig_timing_monitor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StWait = ST_WAIT,
    StRun  = ST_RUN
  } ch_state_e;

  // Counters up to 32 bits wide share this; callers zero-extend and truncate.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/stm_channel.sv
// One monitored channel: edge detect, state machine, width/period counters and checks.
// Emits single-cycle violation set pulses in the cycle the offending edge is on the input.
module stm_channel
  import sig_timing_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] min_width_i,
  input  logic [CNT_W-1:0] min_period_i,
  input  logic [CNT_W-1:0] max_period_i,
  output logic             width_set_o,
  output logic             period_set_o,
  output logic [CNT_W-1:0] last_period_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic             sig_q;
  logic [CNT_W-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             hi_done_q, hi_done_d;
  logic             tmo_done_q, tmo_done_d;
  logic             rise, fall;
  logic             width_short, period_bad;

  assign rise = sig_i & ~sig_q;
  assign fall = ~sig_i & sig_q;

  assign width_short = (min_width_i != '0) && (lvl_q < min_width_i);
  assign period_bad  = ((min_period_i != '0) && (per_q < min_period_i)) ||
                       ((max_period_i != '0) && (per_q > max_period_i));

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    per_d        = per_q;
    last_d       = last_q;
    hi_done_d    = hi_done_q;
    tmo_done_d   = tmo_done_q;
    width_set_o  = 1'b0;
    period_set_o = 1'b0;

    case (state_q)
      StIdle: begin
        if (en_i) state_d = StWait;
      end
      StWait: begin
        if (rise) begin
          state_d = StRun;
          lvl_d   = CntOne;
          per_d   = CntOne;
        end
      end
      StRun: begin
        lvl_d = (rise || fall) ? CntOne : CNT_W'(sat_inc(32'(lvl_q), 32'(CntMax)));
        per_d = rise ? CntOne : CNT_W'(sat_inc(32'(per_q), 32'(CntMax)));
        if (fall) begin
          hi_done_d = 1'b1;
          if (width_short) width_set_o = 1'b1;
        end
        if (rise) begin
          // Low time is only meaningful once a full high phase has been seen.
          if (hi_done_q && width_short) width_set_o = 1'b1;
          if (period_bad) period_set_o = 1'b1;
          last_d     = per_q;
          tmo_done_d = 1'b0;
        end else if ((max_period_i != '0) && (per_q == max_period_i) && !tmo_done_q) begin
          period_set_o = 1'b1;
          tmo_done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en_i) begin
      state_d      = StIdle;
      lvl_d        = '0;
      per_d        = '0;
      hi_done_d    = 1'b0;
      tmo_done_d   = 1'b0;
      width_set_o  = 1'b0;
      period_set_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sig_q      <= 1'b0;
      lvl_q      <= '0;
      per_q      <= '0;
      last_q     <= '0;
      hi_done_q  <= 1'b0;
      tmo_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_i;
      lvl_q      <= lvl_d;
      per_q      <= per_d;
      last_q     <= last_d;
      hi_done_q  <= hi_done_d;
      tmo_done_q <= tmo_done_d;
    end
  end

  assign last_period_o = last_q;

endmodule

// File: rtl/sig_timing_monitor.sv
// Run-time width/period monitor for CH clk-synchronous signals.
// Sticky violation flags, a registered irq and a selectable last-period readback.
module sig_timing_monitor
  import sig_timing_monitor_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    sig_in,
  input  logic [CH-1:0]    ch_en,
  input  logic [CNT_W-1:0] min_width,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  input  logic             clr_viol,
  input  logic [SEL_W-1:0] meas_sel,
  output logic [CH-1:0]    viol_width,
  output logic [CH-1:0]    viol_period,
  output logic             irq,
  output logic [CNT_W-1:0] meas_period
);

  logic [CH-1:0]    width_set, period_set;
  logic [CNT_W-1:0] last_period [CH];
  logic [CH-1:0]    viol_width_q, viol_width_d;
  logic [CH-1:0]    viol_period_q, viol_period_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] meas_q, meas_d;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    stm_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .sig_i        (sig_in[g]),
      .en_i         (ch_en[g]),
      .min_width_i  (min_width),
      .min_period_i (min_period),
      .max_period_i (max_period),
      .width_set_o  (width_set[g]),
      .period_set_o (period_set[g]),
      .last_period_o(last_period[g])
    );
  end

  always_comb begin
    // A set in the same cycle as a clear wins.
    viol_width_d  = (viol_width_q & ~{CH{clr_viol}}) | width_set;
    viol_period_d = (viol_period_q & ~{CH{clr_viol}}) | period_set;
    irq_d         = |{viol_width_q, viol_period_q};
    meas_d        = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (32'(meas_sel) == i) meas_d = last_period[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_width_q  <= '0;
      viol_period_q <= '0;
      irq_q         <= 1'b0;
      meas_q        <= '0;
    end else begin
      viol_width_q  <= viol_width_d;
      viol_period_q <= viol_period_d;
      irq_q         <= irq_d;
      meas_q        <= meas_d;
    end
  end

  assign viol_width  = viol_width_q;
  assign viol_period = viol_period_q;
  assign irq         = irq_q;
  assign meas_period = meas_q;

endmodule

// File: tb/tb_sig_timing_monitor.sv
// Self-checking bench: timestamp-based reference model plus directed scenarios and random traffic.
module tb_sig_timing_monitor;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sig_in, ch_en;
  logic [15:0] min_width, min_period, max_period;
  logic        clr_viol;
  logic [1:0]  meas_sel;
  logic [3:0]  viol_width, viol_period;
  logic        irq;
  logic [15:0] meas_period;

  // Narrow instance for saturation and out-of-range select.
  logic        s_rst;
  logic [2:0]  s_sig, s_en;
  logic [3:0]  s_mw, s_minp, s_maxp;
  logic        s_clr;
  logic [1:0]  s_sel;
  logic [2:0]  s_vw, s_vp;
  logic        s_irq;
  logic [3:0]  s_meas;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sig_timing_monitor #(.CH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ch_en(ch_en), .min_width(min_width),
    .min_period(min_period), .max_period(max_period), .clr_viol(clr_viol),
    .meas_sel(meas_sel), .viol_width(viol_width), .viol_period(viol_period),
    .irq(irq), .meas_period(meas_period)
  );

  sig_timing_monitor #(.CH(3), .CNT_W(4)) dut_s (
    .clk(clk), .rst(s_rst), .sig_in(s_sig), .ch_en(s_en), .min_width(s_mw),
    .min_period(s_minp), .max_period(s_maxp), .clr_viol(s_clr),
    .meas_sel(s_sel), .viol_width(s_vw), .viol_period(s_vp),
    .irq(s_irq), .meas_period(s_meas)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers when its last rise and last edge happened;
  // widths and periods are plain timestamp differences clipped to the counter range.
  int unsigned now;
  int          m_mode [CH];   // 0 disabled, 1 armed, 2 measuring
  int unsigned t_rise [CH];
  int unsigned t_edge [CH];
  bit          hi_done[CH];
  bit          prev   [CH];
  logic [3:0]  e_vw, e_vp;
  logic        e_irq;
  logic [15:0] e_last [CH];
  logic [15:0] e_meas;

  function automatic int unsigned clip16(input int unsigned d);
    return (d > 65535) ? 65535 : d;
  endfunction

  task automatic model_reset();
    now = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; t_rise[c] = 0; t_edge[c] = 0; hi_done[c] = 0; prev[c] = 0;
      e_last[c] = '0;
    end
    e_vw = '0; e_vp = '0; e_irq = 1'b0; e_meas = '0;
  endtask

  task automatic step();
    logic [3:0]  setw, setp;
    logic [15:0] n_last [CH];
    logic        n_irq;
    logic [15:0] n_meas;
    int unsigned lvl, per;
    bit          r, f;
    setw   = '0;
    setp   = '0;
    n_irq  = |{e_vw, e_vp};
    n_meas = (int'(meas_sel) < CH) ? e_last[meas_sel] : 16'd0;
    for (int c = 0; c < CH; c++) begin
      n_last[c] = e_last[c];
      r = sig_in[c] && !prev[c];
      f = !sig_in[c] && prev[c];
      if (!ch_en[c]) m_mode[c] = 0;
      else if (m_mode[c] == 0) m_mode[c] = 1;
      else if (m_mode[c] == 1) begin
        if (r) begin
          m_mode[c] = 2; t_rise[c] = now; t_edge[c] = now; hi_done[c] = 0;
        end
      end else begin
        lvl = clip16(now - t_edge[c]);
        per = clip16(now - t_rise[c]);
        if (f) begin
          if (min_width != 0 && lvl < min_width) setw[c] = 1'b1;
          hi_done[c] = 1;
          t_edge[c]  = now;
        end
        if (r) begin
          if (hi_done[c] && min_width != 0 && lvl < min_width) setw[c] = 1'b1;
          if ((min_period != 0 && per < min_period) || (max_period != 0 && per > max_period))
            setp[c] = 1'b1;
          n_last[c] = 16'(per);
          t_rise[c] = now;
          t_edge[c] = now;
        end else if (max_period != 0 && (now - t_rise[c]) == max_period) begin
          setp[c] = 1'b1;
        end
      end
      prev[c] = sig_in[c];
    end
    now++;
    @(posedge clk);
    #1;
    e_vw   = (e_vw & ~{4{clr_viol}}) | setw;
    e_vp   = (e_vp & ~{4{clr_viol}}) | setp;
    e_irq  = n_irq;
    e_meas = n_meas;
    for (int c = 0; c < CH; c++) e_last[c] = n_last[c];
    check_eq("viol_width", 32'(viol_width), 32'(e_vw));
    check_eq("viol_period", 32'(viol_period), 32'(e_vp));
    check_eq("irq", 32'(irq), 32'(e_irq));
    check_eq("meas_period", 32'(meas_period), 32'(e_meas));
  endtask

  task automatic drive(input int c, input logic v, input int n);
    sig_in[c] = v;
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int first;
    int hold[CH];
    rst = 1'b1; s_rst = 1'b1;
    sig_in = '0; ch_en = '0; min_width = '0; min_period = '0; max_period = '0;
    clr_viol = 1'b0; meas_sel = '0;
    s_sig = '0; s_en = '0; s_mw = '0; s_minp = '0; s_maxp = '0; s_clr = 1'b0; s_sel = '0;
    #2;
    check_eq("rst_vw", 32'(viol_width), 0);
    check_eq("rst_vp", 32'(viol_period), 0);
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_meas", 32'(meas_period), 0);
    #10;
    rst = 1'b0; s_rst = 1'b0;
    model_reset();

    // 1: ch0 toggling every 4 cycles, period 8
    min_width = 16'd2; ch_en = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      sig_in[0] = ((k / 4) % 2) == 1;
      step();
    end
    check_eq("t1_meas", 32'(meas_period), 8);
    check_eq("t1_vw", 32'(viol_width), 0);

    // 2: one-cycle high glitch
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 1);
    check_eq("t2_vw0", 32'(viol_width[0]), 1);
    check_eq("t2_irq_lag", 32'(irq), 0);
    step();
    check_eq("t2_irq", 32'(irq), 1);
    ch_en = '0; clr_viol = 1'b1; step();
    clr_viol = 1'b0; step(); step();
    check_eq("t2_clr_irq", 32'(irq), 0);

    // 3: periods 8, 4, 12 against [6,10]
    min_period = 16'd6; max_period = 16'd10; ch_en = 4'b0010; step();
    drive(1, 1'b1, 4); drive(1, 1'b0, 4);
    drive(1, 1'b1, 2); drive(1, 1'b0, 2);
    check_eq("t3_ok8", 32'(viol_period[1]), 0);
    drive(1, 1'b1, 1);
    check_eq("t3_short4", 32'(viol_period[1]), 1);
    drive(1, 1'b1, 5); drive(1, 1'b0, 6); drive(1, 1'b1, 1);
    check_eq("t3_keep12", 32'(viol_period[1]), 1);
    check_eq("t3_meas_sel0", 32'(meas_period), 8);
    ch_en = '0; sig_in = '0; clr_viol = 1'b1; step();
    clr_viol = 1'b0; step();

    // 4: ch2 stuck low after entering RUN
    min_period = '0; max_period = 16'd10; ch_en = 4'b0100; step();
    drive(2, 1'b1, 1);
    sig_in[2] = 1'b0;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (first == 0 && viol_period[2]) first = k;
    end
    check_eq("t4_tmo_cycle", 32'(first), 10);
    clr_viol = 1'b1; step(); clr_viol = 1'b0;
    repeat (20) step();
    check_eq("t4_once", 32'(viol_period[2]), 0);

    // 5: clear coinciding with a new timeout on ch3
    ch_en = '0; step();
    ch_en = 4'b1000; step();
    drive(3, 1'b1, 1);
    sig_in[3] = 1'b0;
    repeat (9) step();
    clr_viol = 1'b1; step(); clr_viol = 1'b0;
    check_eq("t5_set_wins", 32'(viol_period[3]), 1);
    step();
    check_eq("t5_irq", 32'(irq), 1);
    repeat (3) step();
    clr_viol = 1'b1; step(); clr_viol = 1'b0;
    check_eq("t5_cleared", 32'(viol_period[3]), 0);
    check_eq("t5_irq_lag", 32'(irq), 1);
    step();
    check_eq("t5_irq_drop", 32'(irq), 0);
    ch_en = '0; step();

    // 6: narrow counters saturate at 15, out-of-range select, async reset
    s_mw = 4'd15; s_en = 3'b001; step();
    s_sig[0] = 1'b1;
    repeat (20) step();
    s_sig[0] = 1'b0; step();
    check_eq("t6_no_wrap", 32'(s_vw), 0);
    step(); step();
    s_sig[0] = 1'b1; step();
    check_eq("t6_low_short", 32'(s_vw), 1);
    step();
    check_eq("t6_per_sat", 32'(s_meas), 15);
    s_sel = 2'd3; step();
    check_eq("t6_sel_oor", 32'(s_meas), 0);
    s_sel = 2'd0; step();
    check_eq("t6_sel_back", 32'(s_meas), 15);
    #3 s_rst = 1'b1;
    #1;
    check_eq("t6_rst_vw", 32'(s_vw), 0);
    check_eq("t6_rst_irq", 32'(s_irq), 0);
    check_eq("t6_rst_meas", 32'(s_meas), 0);
    step();
    s_rst = 1'b0;

    // Random traffic, limits changed only while channels are disabled
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 12);
    for (int seg = 0; seg < 8; seg++) begin
      ch_en = '0; step();
      min_width  = 16'($urandom_range(0, 4));
      min_period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(3, 8));
      max_period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(8, 20));
      ch_en = 4'($urandom_range(1, 15));
      for (int k = 0; k < 200; k++) begin
        for (int c = 0; c < CH; c++) begin
          if (hold[c] == 0) begin
            sig_in[c] = ~sig_in[c];
            hold[c]   = $urandom_range(1, 12);
          end else begin
            hold[c]--;
          end
        end
        clr_viol = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 7) == 0) meas_sel = 2'($urandom_range(0, 3));
        step();
      end
      clr_viol = 1'b0;
    end

    // Asynchronous reset mid-run
    #3 rst = 1'b1;
    #1;
    check_eq("arst_vw", 32'(viol_width), 0);
    check_eq("arst_vp", 32'(viol_period), 0);
    check_eq("arst_irq", 32'(irq), 0);
    check_eq("arst_meas", 32'(meas_period), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
